// File: rtl/wb_stage_if.sv
// Bundle interface between the memory stage and the write-back stage.
// The master modport is the MEM side; the slave modport is wb_stage.
interface wb_stage_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 16
);
  logic              stall_in;
  logic              flush_in;
  logic [ADDR_W-1:0] Rdst1_in;
  logic [DATA_W-1:0] Rdst1_val_in;
  logic [ADDR_W-1:0] Rdst2_in;
  logic [DATA_W-1:0] Rdst2_val_in;
  logic              reglow_write_in;
  logic              reghigh_write_in;
  logic [DATA_W-1:0] Data_in;
  logic              memToReg_in;

  logic              rf_we_out;
  logic [ADDR_W-1:0] rf_addr_out;
  logic [DATA_W-1:0] rf_data_out;
  logic [DATA_W-1:0] DATA_WB_out;
  logic [ADDR_W-1:0] Rdst_WB_out;
  logic              busy_out;
  logic [CNT_W-1:0]  retired_out;

  modport master (
    output stall_in, flush_in, Rdst1_in, Rdst1_val_in, Rdst2_in, Rdst2_val_in,
           reglow_write_in, reghigh_write_in, Data_in, memToReg_in,
    input  rf_we_out, rf_addr_out, rf_data_out, DATA_WB_out, Rdst_WB_out, busy_out,
           retired_out
  );

  modport slave (
    input  stall_in, flush_in, Rdst1_in, Rdst1_val_in, Rdst2_in, Rdst2_val_in,
           reglow_write_in, reghigh_write_in, Data_in, memToReg_in,
    output rf_we_out, rf_addr_out, rf_data_out, DATA_WB_out, Rdst_WB_out, busy_out,
           retired_out
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB buffer, write-data select, two-cycle dual-write sequencing
// and a retired-instruction counter.
module wb_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 16
) (
  input logic       clk,
  input logic       reset,
  wb_stage_if.slave wb_bus
);

  typedef enum logic {PhLow, PhHigh} phase_e;

  phase_e            r_phase;
  logic              r_valid;
  logic              r_lo;
  logic              r_hi;
  logic [ADDR_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_d1;
  logic [ADDR_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_d2;
  logic [CNT_W-1:0]  r_cnt;

  phase_e            w_phase_d;
  logic              w_busy;
  logic              w_done;
  logic              w_capture;
  logic              w_valid_d;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  always_comb begin
    w_busy    = r_valid & r_lo & r_hi & (r_phase == PhLow);
    w_done    = r_valid & ~w_busy;
    w_capture = ~w_busy;
    w_valid_d = ~wb_bus.stall_in & ~wb_bus.flush_in &
                (wb_bus.reglow_write_in | wb_bus.reghigh_write_in);
    w_phase_d = w_busy ? PhHigh : PhLow;
  end

  // Buffer freezes while the second write is pending; stall/flush are ignored then.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase <= PhLow;
      r_valid <= 1'b0;
      r_lo    <= 1'b0;
      r_hi    <= 1'b0;
      r_rd1   <= '0;
      r_d1    <= '0;
      r_rd2   <= '0;
      r_d2    <= '0;
      r_cnt   <= '0;
    end else begin
      r_phase <= w_phase_d;
      r_cnt   <= r_cnt + {{(CNT_W-1){1'b0}}, w_done};
      if (w_capture) begin
        r_valid <= w_valid_d;
        r_lo    <= wb_bus.reglow_write_in;
        r_hi    <= wb_bus.reghigh_write_in;
        r_rd1   <= wb_bus.Rdst1_in;
        r_d1    <= wb_bus.memToReg_in ? wb_bus.Data_in : wb_bus.Rdst1_val_in;
        r_rd2   <= wb_bus.Rdst2_in;
        r_d2    <= wb_bus.Rdst2_val_in;
      end
    end
  end

  always_comb begin
    w_we   = r_valid;
    w_addr = '0;
    w_data = '0;
    if (r_valid) begin
      if ((r_phase == PhLow) && r_lo) begin
        w_addr = r_rd1;
        w_data = r_d1;
      end else begin
        w_addr = r_rd2;
        w_data = r_d2;
      end
    end
  end

  assign wb_bus.rf_we_out   = w_we;
  assign wb_bus.rf_addr_out = w_addr;
  assign wb_bus.rf_data_out = w_data;
  assign wb_bus.DATA_WB_out = w_data;
  assign wb_bus.Rdst_WB_out = w_addr;
  assign wb_bus.busy_out    = w_busy;
  assign wb_bus.retired_out = r_cnt;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized bench for wb_stage against a queue-of-pending-writes reference model.
module tb_wb_stage;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;

  logic clk;
  logic reset;

  wb_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(16)) bus ();
  wb_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(4))  bus4 ();

  wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(16)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .wb_bus (bus.slave)
  );

  wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(4)) u_dut4 (
    .clk    (clk),
    .reset  (reset),
    .wb_bus (bus4.slave)
  );

  assign bus4.stall_in         = bus.stall_in;
  assign bus4.flush_in         = bus.flush_in;
  assign bus4.Rdst1_in         = bus.Rdst1_in;
  assign bus4.Rdst1_val_in     = bus.Rdst1_val_in;
  assign bus4.Rdst2_in         = bus.Rdst2_in;
  assign bus4.Rdst2_val_in     = bus.Rdst2_val_in;
  assign bus4.reglow_write_in  = bus.reglow_write_in;
  assign bus4.reghigh_write_in = bus.reghigh_write_in;
  assign bus4.Data_in          = bus.Data_in;
  assign bus4.memToReg_in      = bus.memToReg_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    bit                last;
  } wr_t;

  wr_t q[$];
  int unsigned n_retired;
  int n_total;
  int n_bad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    n_retired = 0;
  endtask

  // Each edge retires the head write; the stage accepts a new bundle once nothing is left.
  task automatic model_edge();
    wr_t w;
    bit  busy;
    busy = (q.size() == 2);
    if (q.size() > 0) begin
      if (q[0].last) n_retired++;
      void'(q.pop_front());
    end
    if (!busy && !bus.stall_in && !bus.flush_in) begin
      if (bus.reglow_write_in) begin
        w.a    = bus.Rdst1_in;
        w.d    = bus.memToReg_in ? bus.Data_in : bus.Rdst1_val_in;
        w.last = !bus.reghigh_write_in;
        q.push_back(w);
      end
      if (bus.reghigh_write_in) begin
        w.a    = bus.Rdst2_in;
        w.d    = bus.Rdst2_val_in;
        w.last = 1'b1;
        q.push_back(w);
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] e_we, e_a, e_d;
    e_we = (q.size() > 0) ? 1 : 0;
    e_a  = (q.size() > 0) ? 32'(q[0].a) : 0;
    e_d  = (q.size() > 0) ? 32'(q[0].d) : 0;
    check_eq({tag, ".we"},      32'(bus.rf_we_out),   e_we);
    check_eq({tag, ".addr"},    32'(bus.rf_addr_out), e_a);
    check_eq({tag, ".data"},    32'(bus.rf_data_out), e_d);
    check_eq({tag, ".fwd"},     32'(bus.DATA_WB_out), e_d);
    check_eq({tag, ".rdst"},    32'(bus.Rdst_WB_out), e_a);
    check_eq({tag, ".busy"},    32'(bus.busy_out),    (q.size() == 2) ? 1 : 0);
    check_eq({tag, ".ret"},     32'(bus.retired_out), n_retired & 32'hFFFF);
    check_eq({tag, ".ret4"},    32'(bus4.retired_out), n_retired & 32'hF);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic set_in(input bit st, input bit fl, input bit lo, input bit hi, input bit m2r,
                        input logic [2:0] r1, input logic [15:0] v1, input logic [2:0] r2,
                        input logic [15:0] v2, input logic [15:0] din);
    bus.stall_in         = st;
    bus.flush_in         = fl;
    bus.reglow_write_in  = lo;
    bus.reghigh_write_in = hi;
    bus.memToReg_in      = m2r;
    bus.Rdst1_in         = r1;
    bus.Rdst1_val_in     = v1;
    bus.Rdst2_in         = r2;
    bus.Rdst2_val_in     = v2;
    bus.Data_in          = din;
  endtask

  task automatic set_bubble();
    set_in(0, 0, 0, 0, 0, 3'd0, 16'h0, 3'd0, 16'h0, 16'h0);
  endtask

  task automatic set_random();
    set_in(($urandom_range(7) == 0), ($urandom_range(7) == 0), 1'($urandom), 1'($urandom),
           1'($urandom), 3'($urandom), 16'($urandom), 3'($urandom), 16'($urandom),
           16'($urandom));
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    model_reset();
    set_bubble();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all("rst");
    reset = 1'b1;

    // Plain ALU write, then the retirement shows one edge later.
    set_in(0, 0, 1, 0, 0, 3'd3, 16'h1234, 3'd0, 16'h0, 16'h0);
    tick("t1a");
    check_eq("t1.data", 32'(bus.rf_data_out), 32'h1234);
    set_bubble();
    tick("t1b");
    check_eq("t1.ret", 32'(bus.retired_out), 1);

    // Load selects Data_in.
    set_in(0, 0, 1, 0, 1, 3'd5, 16'h0001, 3'd0, 16'h0, 16'hBEEF);
    tick("t2a");
    check_eq("t2.data", 32'(bus.rf_data_out), 32'hBEEF);
    set_bubble();
    tick("t2b");

    // SWAP followed by a held single write.
    set_in(0, 0, 1, 1, 0, 3'd1, 16'hAAAA, 3'd2, 16'h5555, 16'h0);
    tick("t3a");
    check_eq("t3.busy1", 32'(bus.busy_out), 1);
    set_in(0, 0, 1, 0, 0, 3'd4, 16'h4444, 3'd0, 16'h0, 16'h0);
    tick("t3b");
    check_eq("t3.addr2", 32'(bus.rf_addr_out), 2);
    tick("t3c");
    check_eq("t3.addr3", 32'(bus.rf_addr_out), 4);
    set_bubble();
    tick("t3d");
    check_eq("t3.ret", 32'(bus.retired_out), 4);

    // Stall and flush squash; flush during busy does not abort the second write.
    set_in(1, 0, 1, 0, 0, 3'd6, 16'h6666, 3'd0, 16'h0, 16'h0);
    tick("t4a");
    set_in(0, 1, 1, 0, 0, 3'd6, 16'h6666, 3'd0, 16'h0, 16'h0);
    tick("t4b");
    set_in(0, 0, 1, 1, 0, 3'd7, 16'h7777, 3'd7, 16'h8888, 16'h0);
    tick("t4c");
    set_in(0, 1, 1, 0, 0, 3'd1, 16'h1111, 3'd0, 16'h0, 16'h0);
    tick("t4d");
    check_eq("t4.second", 32'(bus.rf_data_out), 32'h8888);
    set_bubble();
    tick("t4e");

    // Reset in the HIGH phase clears outputs immediately.
    set_in(0, 0, 1, 1, 0, 3'd2, 16'h2222, 3'd3, 16'h3333, 16'h0);
    tick("t5a");
    #2 reset = 1'b0;
    model_reset();
    #1 check_all("t5rst");
    @(posedge clk);
    @(negedge clk);
    check_all("t5hold");
    set_bubble();
    reset = 1'b1;
    tick("t5rel");

    for (int i = 0; i < 600; i++) begin
      set_random();
      tick("rnd");
    end
    set_bubble();
    tick("end0");
    tick("end1");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage directly downstream of the memory stage.
- Registers the memory-stage result bundle (MEM/WB buffer), selects write-back data and drives the register file's single write port.
- Sequences two-register writes (SWAP, 32-bit results) over two cycles, stalling upstream while it does so.
- Drives DATA_WB_out for forwarding unit 2 and keeps a retired-instruction counter.

Parameters:
DATA_W, 16, register/data width
ADDR_W, 3, register index width
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
stall_in  in  1  MEM stage stalled this cycle (e.g. PUSH/POP PC second cycle); capture a bubble
flush_in  in  1  squash the bundle presented this cycle; capture a bubble
Rdst1_in  in  ADDR_W  first destination register
Rdst1_val_in  in  DATA_W  ALU result for Rdst1
Rdst2_in  in  ADDR_W  second destination register
Rdst2_val_in  in  DATA_W  value for Rdst2
reglow_write_in  in  1  write Rdst1
reghigh_write_in  in  1  write Rdst2
Data_in  in  DATA_W  memory/port read data from MEM stage
memToReg_in  in  1  Rdst1 gets Data_in instead of Rdst1_val_in
rf_we_out  out  1  register file write enable
rf_addr_out  out  ADDR_W  register file write address
rf_data_out  out  DATA_W  register file write data
DATA_WB_out  out  DATA_W  forwarded write-back value (equals rf_data_out)
Rdst_WB_out  out  ADDR_W  register being written this cycle (for FU2 compare)
busy_out  out  1  second write pending; upstream must hold
retired_out  out  CNT_W  count of instructions that completed write-back

Behaviour:
- Reset (reset=0, async):
  - buffer valid=0, phase=0, counter=0.
  - All outputs 0: rf_we_out, rf_addr_out, rf_data_out, DATA_WB_out, Rdst_WB_out, busy_out, retired_out.
- Buffer capture, at posedge when busy_out=0:
  - stall_in=1 or flush_in=1: load a bubble (valid=0).
  - Otherwise: latch the full bundle, with valid = reglow_write_in | reghigh_write_in.
  - Low-word data is resolved at capture: memToReg_in ? Data_in : Rdst1_val_in.
  - busy_out=1: buffer holds; stall_in and flush_in are ignored. An in-flight dual write is never aborted.
- Latency: a bundle captured at edge N is written to the register file at edge N+1. Dual write: the second write lands at edge N+2.
- Phase state machine (phase bit, only meaningful while valid=1):
  - LOW (phase=0):
    - both write bits set: write Rdst1/low data; busy_out=1; next state HIGH.
    - only low set: write Rdst1; instruction completes.
    - only high set: write Rdst2/Rdst2_val; instruction completes.
  - HIGH (phase=1): write Rdst2/Rdst2_val; busy_out=0; instruction completes. At that edge a new bundle may be captured and phase returns to LOW.
  - valid=0: rf_we_out=0; rf_addr_out and rf_data_out hold 0.
- busy_out = valid & both-writes & (phase==0), combinational from registered state only; no input-to-busy_out path.
- Rdst1==Rdst2 with both writes: still two cycles; the Rdst2 value is written last and wins.
- DATA_WB_out and Rdst_WB_out mirror rf_data_out and rf_addr_out in every cycle.
- retired_out increments by 1 on each edge where an instruction completes. Bubbles do not count. Wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-dual-write: the pending second write is lost; all state clears immediately.

Test Plan:
1. Reset released; present Rdst1=3, Rdst1_val=0x1234, reglow=1 -> next cycle rf_we=1, rf_addr=3, rf_data=0x1234, DATA_WB=0x1234; retired_out=1 after the following edge.
2. Load: memToReg=1, Data_in=0xBEEF, Rdst1_val=0x0001, Rdst1=5 -> rf_data=0xBEEF, rf_addr=5; single cycle, busy_out stays 0.
3. SWAP: reglow=reghigh=1, Rdst1=1/0xAAAA, Rdst2=2/0x5555; new bundle Rdst1=4 held at inputs -> cycle1 writes R1=0xAAAA with busy_out=1; cycle2 writes R2=0x5555 with busy_out=0; cycle3 writes R4; retired_out +1 per instruction, never +2.
4. stall_in=1 or flush_in=1 with a valid bundle -> no write next cycle, retired_out unchanged. flush_in=1 during busy_out=1 -> the second write still occurs.
5. Reset pulsed low while in HIGH phase -> outputs 0 immediately (before next edge); no Rdst2 write after release.
6. Preload the counter near the top (CNT_W=4 variant, 16 retirements) -> retired_out wraps from 15 to 0.
